// File: rtl/pump_arbiter.sv
// Round-robin arbiter sharing one pump relay and per-station valves between dispense stations.
// Each grant runs valve settle, timed pumping and valve release, then pulses done or aborted.
module pump_arbiter #(
  parameter int REQUESTER_COUNT      = 4,
  parameter int NS_PER_ML            = 1000000,
  parameter int CLOCK_PERIOD_IN_NS   = 20,
  parameter int SETTLE_CYCLES        = 50000,
  parameter int MAXIMUM_VOLUME_IN_ML = 9999
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [REQUESTER_COUNT-1:0]    request,
  input  logic [14*REQUESTER_COUNT-1:0] amount_in_ml,
  input  logic [REQUESTER_COUNT-1:0]    cancel,
  output logic [REQUESTER_COUNT-1:0]    grant,
  output logic [REQUESTER_COUNT-1:0]    valve,
  output logic                          relay,
  output logic                          busy,
  output logic [13:0]                   target_in_ml,
  output logic [13:0]                   dispensed_in_ml,
  output logic [REQUESTER_COUNT-1:0]    done,
  output logic [REQUESTER_COUNT-1:0]    aborted
);

  localparam int CYCLES_PER_ML = NS_PER_ML / CLOCK_PERIOD_IN_NS;
  localparam int PW = $clog2(REQUESTER_COUNT);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int MW = $clog2(CYCLES_PER_ML + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [MW-1:0] ML_LAST     = MW'(CYCLES_PER_ML - 1);
  localparam logic [13:0]   MAX_ML      = 14'(MAXIMUM_VOLUME_IN_ML);

  typedef enum logic [1:0] {IDLE, SETTLE, PUMPING, RELEASE} state_t;

  state_t                     state;
  logic [PW-1:0]              pointer;
  logic [PW-1:0]              owner;
  logic [SW-1:0]              settle_count;
  logic [MW-1:0]              ml_count;
  logic                       abort_pending;
  logic [REQUESTER_COUNT-1:0] eligible;
  logic                       win_found;
  logic [PW-1:0]              win_idx;
  logic [13:0]                win_amount;
  logic                       stop_now;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= REQUESTER_COUNT) sum = sum - REQUESTER_COUNT;
    return PW'(sum);
  endfunction

  // A station that just pulsed done/aborted sits out the first IDLE cycle so others get a turn.
  always_comb begin
    eligible = '0;
    for (int k = 0; k < REQUESTER_COUNT; k++)
      eligible[k] = request[k] && (amount_in_ml[14*k +: 14] != 14'd0) && !done[k] && !aborted[k];
  end

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < REQUESTER_COUNT; i++) begin
      if (!win_found && eligible[wrap_add(pointer, i)]) begin
        win_found = 1'b1;
        win_idx   = wrap_add(pointer, i);
      end
    end
  end

  assign win_amount = amount_in_ml[14*int'(win_idx) +: 14];
  assign stop_now   = cancel[owner] || !request[owner];
  assign valve      = grant;
  assign busy       = (state != IDLE);

  // Stop requests take priority over completing the last ml, so a late cancel still aborts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      pointer         <= '0;
      owner           <= '0;
      grant           <= '0;
      relay           <= 1'b1;
      target_in_ml    <= '0;
      dispensed_in_ml <= '0;
      done            <= '0;
      aborted         <= '0;
      settle_count    <= '0;
      ml_count        <= '0;
      abort_pending   <= 1'b0;
    end else begin
      done    <= '0;
      aborted <= '0;
      case (state)
        IDLE: begin
          if (win_found) begin
            state           <= SETTLE;
            owner           <= win_idx;
            grant           <= REQUESTER_COUNT'(1) << win_idx;
            pointer         <= wrap_add(win_idx, 1);
            target_in_ml    <= (win_amount > MAX_ML) ? MAX_ML : win_amount;
            dispensed_in_ml <= '0;
            settle_count    <= '0;
            abort_pending   <= 1'b0;
            relay           <= 1'b1;
          end
        end
        SETTLE: begin
          if (stop_now) begin
            state         <= RELEASE;
            abort_pending <= 1'b1;
            settle_count  <= '0;
          end else if (settle_count == SETTLE_LAST) begin
            state    <= PUMPING;
            relay    <= 1'b0;
            ml_count <= '0;
          end else begin
            settle_count <= settle_count + 1'b1;
          end
        end
        PUMPING: begin
          if (stop_now) begin
            state         <= RELEASE;
            relay         <= 1'b1;
            abort_pending <= 1'b1;
            settle_count  <= '0;
          end else if (ml_count == ML_LAST) begin
            ml_count        <= '0;
            dispensed_in_ml <= dispensed_in_ml + 14'd1;
            if (dispensed_in_ml + 14'd1 == target_in_ml) begin
              state        <= RELEASE;
              relay        <= 1'b1;
              settle_count <= '0;
            end
          end else begin
            ml_count <= ml_count + 1'b1;
          end
        end
        RELEASE: begin
          if (settle_count == SETTLE_LAST) begin
            state <= IDLE;
            grant <= '0;
            if (abort_pending) aborted <= grant;
            else               done    <= grant;
          end else begin
            settle_count <= settle_count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pump_arbiter.md
Name: pump_arbiter

Overview:
- Shares one pump (relay) and a bank of per-station valves between REQUESTER_COUNT dispense stations.
- Each station front end holds a level request and a volume in ml.
- The arbiter grants stations round-robin and sequences each dispense: valve settle, timed pumping, valve release.
- It reports ml dispensed live and pulses done or aborted per station.

Parameters:
- REQUESTER_COUNT, 4: number of stations (2..8).
- NS_PER_ML, 1000000: pump-on time per ml, in ns.
- CLOCK_PERIOD_IN_NS, 20: clock period. CYCLES_PER_ML = NS_PER_ML / CLOCK_PERIOD_IN_NS (integer, >= 1).
- SETTLE_CYCLES, 50000: valve-open time before pumping and after pumping (>= 1).
- MAXIMUM_VOLUME_IN_ML, 9999: clamp for requested volume.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- request  in  REQUESTER_COUNT  level request per station; held until done/aborted.
- amount_in_ml  in  14*REQUESTER_COUNT  packed volumes; station k uses bits [14k+13:14k].
- cancel  in  REQUESTER_COUNT  per-station cancel, already a one-cycle pulse.
- grant  out  REQUESTER_COUNT  one-hot owner of the pump; zero when idle.
- valve  out  REQUESTER_COUNT  valve drive; equals grant outside IDLE.
- relay  out  1  pump relay, active-low: 0 = pump on.
- busy  out  1  high whenever state != IDLE.
- target_in_ml  out  14  latched (clamped) volume of current grant.
- dispensed_in_ml  out  14  whole ml pumped for current/last grant.
- done  out  REQUESTER_COUNT  one-cycle pulse: dispense completed.
- aborted  out  REQUESTER_COUNT  one-cycle pulse: dispense cancelled.

Behaviour:
- Reset values:
  - grant = 0, valve = 0, relay = 1, busy = 0.
  - target_in_ml = 0, dispensed_in_ml = 0, done = 0, aborted = 0.
  - Round-robin pointer = 0, state = IDLE.
- Reset is asynchronous and mid-operation: the pump stops and valves close immediately. No done/aborted pulse is issued.
- States: IDLE, SETTLE, PUMPING, RELEASE.
- IDLE:
  - Eligible station = request high and amount != 0.
  - Search starts at the pointer and increases modulo REQUESTER_COUNT; the first eligible station wins.
  - Next cycle: grant/valve one-hot for the winner, state = SETTLE.
  - target_in_ml = min(amount, MAXIMUM_VOLUME_IN_ML); dispensed_in_ml = 0.
  - Pointer = winner + 1 (wraps).
  - A station whose done/aborted pulsed on the previous cycle is not eligible in that IDLE cycle.
- SETTLE: relay = 1 for exactly SETTLE_CYCLES cycles, then PUMPING.
- PUMPING:
  - relay = 0. A sub-counter counts 0..CYCLES_PER_ML-1; on wrap, dispensed_in_ml increments.
  - When dispensed_in_ml reaches target_in_ml, go to RELEASE.
  - relay = 0 for exactly target_in_ml*CYCLES_PER_ML cycles.
- RELEASE: relay = 1, valve still open, for SETTLE_CYCLES cycles. Then IDLE with grant = valve = 0, and done or aborted pulsed on the same edge.
- Cancel:
  - Cancel of the granted station, or its request going low, during SETTLE or PUMPING: next cycle state = RELEASE, relay = 1.
  - dispensed_in_ml freezes; the pending abort flag is set, and the exit pulse is aborted instead of done.
  - During RELEASE, cancel is ignored (the abort flag is unchanged).
  - Cancel for a non-granted station is ignored.
- Simultaneous: if cancel arrives on the cycle the final ml completes, the cancel wins (aborted).
- Changes to amount_in_ml after grant have no effect.
- done and aborted are never high together.
- dispensed_in_ml holds its value in IDLE until the next grant.

Test Plan:
(Use NS_PER_ML=100, CLOCK_PERIOD_IN_NS=20, giving CYCLES_PER_ML=5; SETTLE_CYCLES=3; REQUESTER_COUNT=4.)
- Single dispense: request[1]=1, amount 3 → grant=0010 next cycle; relay 1 for 3 cycles, 0 for 15, 1 for 3; dispensed steps 1,2,3; done[1] pulse on the grant-drop edge; grant high 21 cycles total.
- Round-robin: all four requesting, amount 1 each, held → grant order 0,1,2,3,0. A station is never re-granted in the IDLE cycle right after its done.
- Cancel mid-pump: station 2, amount 5, cancel[2] at the 12th PUMPING cycle → relay 1 next cycle; dispensed_in_ml = 2 and frozen; 3 RELEASE cycles; aborted[2] pulse; done stays 0.
- Eligibility and clamp: station 2 amount 0, station 3 amount 12000, both requesting, pointer 2 → station 2 skipped, grant = 1000, target_in_ml = 9999.
- Request drop: station 0 request falls during SETTLE → RELEASE follows; aborted[0] pulse; relay never goes 0.
- Async reset during PUMPING: relay = 1, valve = 0, grant = 0 before the next clock edge; no pulses. After release with stations 1 and 3 requesting → station 1 granted.
